// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the CPU instruction memory.
//
// Receives a framed byte stream (LEN_HI, LEN_LO, 4*N data bytes MSB first,
// XOR checksum byte) over a valid/ready handshake, assembles big-endian
// 32-bit words and writes them to consecutive word addresses. The CPU is
// held in clear until a complete frame with a matching checksum is loaded.
//
// Ports:
//   clk       in   system clock, rising edge
//   clr       in   asynchronous active-high reset
//   start     in   one-cycle load request (honoured in IDLE, RUN, ERR)
//   rx_data   in   [7:0] frame byte
//   rx_valid  in   rx_data valid
//   rx_ready  out  loader can accept a byte
//   mem_addr  out  [ADDR_W-1:0] instruction-memory word address
//   mem_data  out  [31:0] instruction word
//   mem_we    out  one-cycle write strobe per word
//   cpu_clr   out  CPU clear, low only in RUN
//   done      out  program loaded and verified
//   error     out  load failed
module prog_loader #(
   parameter int ADDR_W = 8,
   parameter int WORDS  = 256
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic              mem_we,
   output logic              cpu_clr,
   output logic              done,
   output logic              error
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CSUM   = 3'd4;
   localparam logic [2:0] S_RUN    = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   localparam logic [16:0] WORDS_L = 17'(WORDS);

   logic [2:0]        r_state;
   logic [15:0]       r_len;
   logic [ADDR_W:0]   r_widx;     // one extra bit so N == 2^ADDR_W ends cleanly
   logic [1:0]        r_bidx;
   logic [7:0]        r_acc;
   logic [23:0]       r_asm;      // first three bytes of the word being built
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_data;
   logic              r_mem_we;

   logic              w_rx_ready;
   logic              w_accept;
   logic [15:0]       w_len;
   logic              w_len_bad;
   logic [31:0]       w_word;
   logic [ADDR_W:0]   w_widx_nxt;
   logic              w_last_word;

   // Handshake and datapath helpers derived from current state and input byte.
   always_comb begin
      w_rx_ready  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                    (r_state == S_DATA)   || (r_state == S_CSUM);
      w_accept    = rx_valid && w_rx_ready;
      w_len       = {r_len[15:8], rx_data};
      w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > WORDS_L);
      w_word      = {r_asm, rx_data};
      w_widx_nxt  = r_widx + {{ADDR_W{1'b0}}, 1'b1};
      w_last_word = ({{(15 - ADDR_W){1'b0}}, w_widx_nxt} == r_len);
   end

   // Frame-parsing state machine, word assembly and memory write registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state    <= S_IDLE;
         r_len      <= 16'd0;
         r_widx     <= '0;
         r_bidx     <= 2'd0;
         r_acc      <= 8'd0;
         r_asm      <= 24'd0;
         r_mem_addr <= '0;
         r_mem_data <= 32'd0;
         r_mem_we   <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
               if (start) begin
                  r_state <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len[15:8] <= rx_data;
                  r_state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_accept) begin
                  r_len <= w_len;
                  if (w_len_bad) begin
                     r_state <= S_ERR;
                  end else begin
                     r_widx  <= '0;
                     r_bidx  <= 2'd0;
                     r_acc   <= 8'd0;
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_asm  <= w_word[23:0];
                  r_acc  <= r_acc ^ rx_data;
                  r_bidx <= r_bidx + 2'd1;
                  if (r_bidx == 2'd3) begin
                     // Separate output registers keep the pending write
                     // intact while the next word is being assembled.
                     r_mem_data <= w_word;
                     r_mem_addr <= r_widx[ADDR_W-1:0];
                     r_mem_we   <= 1'b1;
                     r_widx     <= w_widx_nxt;
                     if (w_last_word) begin
                        r_state <= S_CSUM;
                     end
                  end
               end
            end
            S_CSUM: begin
               if (w_accept) begin
                  r_state <= (rx_data == r_acc) ? S_RUN : S_ERR;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_ready = w_rx_ready;
   assign mem_addr = r_mem_addr;
   assign mem_data = r_mem_data;
   assign mem_we   = r_mem_we;
   assign cpu_clr  = (r_state != S_RUN);
   assign done     = (r_state == S_RUN);
   assign error    = (r_state == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
// A table of frame descriptors plus randomized frames are driven through the
// loader; a frame-level reference model predicts the memory writes and the
// final done/error outcome. Hand-written sequences cover the exact example
// frame, reload from RUN and reset in the middle of a load.
module tb_prog_loader;

   logic        clk;
   logic        clr;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data;
   logic        mem_we;
   logic        cpu_clr;
   logic        done;
   logic        error;

   prog_loader #(.ADDR_W(8), .WORDS(256)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_we   (mem_we),
      .cpu_clr  (cpu_clr),
      .done     (done),
      .error    (error)
   );

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      int n;
      bit bad_csum;
      int gap;
      bit pulse;
      bit exp_done;
      bit exp_err;
      int exp_nw;
   } vec_t;

   int   n_vec;
   int   n_miss;
   logic [7:0] frame_q[$];
   wr_t  got_q[$];
   wr_t  exp_q[$];
   bit   m_lenerr;
   bit   m_done;
   bit   m_err;

   always #5 clk = ~clk;

   // Record every cycle in which the write strobe is high.
   always @(negedge clk) begin
      if (mem_we) got_q.push_back('{mem_addr, mem_data});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, need completion)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Frame-level model: decode length, split data into words, XOR all data bytes.
   task automatic model();
      int unsigned n;
      logic [7:0] x;
      exp_q.delete();
      m_lenerr = 0; m_done = 0; m_err = 0;
      n = {frame_q[0], frame_q[1]};
      if (n == 0 || n > 256) begin
         m_lenerr = 1;
         m_err    = 1;
      end else begin
         x = 8'h00;
         for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back('{i[7:0], {frame_q[2+4*i], frame_q[3+4*i],
                                       frame_q[4+4*i], frame_q[5+4*i]}});
            for (int k = 0; k < 4; k++) x = x ^ frame_q[2+4*i+k];
         end
         m_done = (frame_q[2+4*n] == x);
         m_err  = !m_done;
      end
   endtask

   task automatic build(input int n, input bit bad);
      logic [7:0] cs;
      logic [7:0] b;
      frame_q.delete();
      frame_q.push_back(8'(n >> 8));
      frame_q.push_back(8'(n));
      cs = 8'h00;
      if (n >= 1 && n <= 256) begin
         for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            cs = cs ^ b;
         end
         frame_q.push_back(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      int t;
      rx_data = b; rx_valid = 1'b1; acc = 0; t = 0;
      while (!acc && t < 50) begin
         acc = rx_ready;
         @(posedge clk); #1;
         t++;
      end
      rx_valid = 1'b0;
      if (!acc) begin
         n_vec++; n_miss++;
         $display("FAIL byte_accept: rx_ready got 0 for 50 cycles, expected 1");
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_rx_ready", rx_ready, 1);
      chk("start_cpu_clr", cpu_clr, 1);
      chk("start_done", done, 0);
      chk("start_error", error, 0);
   endtask

   task automatic send_bytes(input int cnt, input int gap, input bit pulse);
      for (int i = 0; i < cnt; i++) begin
         if (gap == 1) begin
            @(posedge clk); #1;
         end else if (gap == 2) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         if (pulse && i == 4) start = 1'b1;
         send_byte(frame_q[i]);
         start = 1'b0;
      end
   endtask

   task automatic run_frame(input int gap, input bit pulse, input bit e_done,
                            input bit e_err, input int e_nw);
      model();
      got_q.delete();
      do_start();
      send_bytes(m_lenerr ? 2 : frame_q.size(), gap, pulse);
      if (m_lenerr) begin
         chk("len_err_next_cycle", error, 1);
         repeat (3) begin @(posedge clk); #1; end
      end
      chk("end_done", done, e_done);
      chk("end_error", error, e_err);
      chk("end_cpu_clr", cpu_clr, !e_done);
      chk("end_rx_ready", rx_ready, 0);
      chk("model_done", done, m_done);
      chk("nwrites", got_q.size(), exp_q.size());
      if (e_nw >= 0) chk("nwrites_tbl", got_q.size(), e_nw);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) begin
            chk("wr_addr", got_q[i].a, exp_q[i].a);
            chk("wr_data", got_q[i].d, exp_q[i].d);
         end
      end
      if (exp_q.size() > 0) begin
         chk("hold_addr", mem_addr, exp_q[exp_q.size()-1].a);
         chk("hold_data", mem_data, exp_q[exp_q.size()-1].d);
      end
   endtask

   vec_t tbl[6];

   initial begin
      n_vec = 0; n_miss = 0;
      clk = 1'b0; clr = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

      tbl[0] = '{n: 1,   bad_csum: 0, gap: 0, pulse: 0, exp_done: 1, exp_err: 0, exp_nw: 1};
      tbl[1] = '{n: 2,   bad_csum: 1, gap: 0, pulse: 0, exp_done: 0, exp_err: 1, exp_nw: 2};
      tbl[2] = '{n: 0,   bad_csum: 0, gap: 0, pulse: 0, exp_done: 0, exp_err: 1, exp_nw: 0};
      tbl[3] = '{n: 257, bad_csum: 0, gap: 0, pulse: 0, exp_done: 0, exp_err: 1, exp_nw: 0};
      tbl[4] = '{n: 256, bad_csum: 0, gap: 0, pulse: 0, exp_done: 1, exp_err: 0, exp_nw: 256};
      tbl[5] = '{n: 3,   bad_csum: 0, gap: 1, pulse: 1, exp_done: 1, exp_err: 0, exp_nw: 3};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_cpu_clr", cpu_clr, 1);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      clr = 1'b0;
      @(posedge clk); #1;
      chk("idle_rx_ready", rx_ready, 0);

      // Exact example frame, then reload with a bad checksum, then good again.
      frame_q = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      run_frame(0, 0, 1, 0, 2);
      if (got_q.size() == 2) begin
         chk("ex_addr0", got_q[0].a, 8'h00);
         chk("ex_data0", got_q[0].d, 32'h0000_0001);
         chk("ex_addr1", got_q[1].a, 8'h01);
         chk("ex_data1", got_q[1].d, 32'h1234_5678);
      end
      frame_q[10] = 8'h00;
      run_frame(0, 0, 0, 1, 2);
      frame_q[10] = 8'h09;
      run_frame(2, 0, 1, 0, 2);

      // Reset after the 6th byte: outputs return to reset values at once.
      do_start();
      send_bytes(6, 0, 0);
      clr = 1'b1;
      #1;
      chk("midrst_rx_ready", rx_ready, 0);
      chk("midrst_mem_we", mem_we, 0);
      chk("midrst_mem_addr", mem_addr, 0);
      chk("midrst_mem_data", mem_data, 0);
      chk("midrst_cpu_clr", cpu_clr, 1);
      chk("midrst_done", done, 0);
      chk("midrst_error", error, 0);
      @(posedge clk); #1;
      clr = 1'b0;
      @(posedge clk); #1;
      chk("midrst_idle_rx_ready", rx_ready, 0);
      run_frame(0, 0, 1, 0, 2);

      // Table-driven frames.
      for (int v = 0; v < 6; v++) begin
         build(tbl[v].n, tbl[v].bad_csum);
         run_frame(tbl[v].gap, tbl[v].pulse, tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_nw);
      end

      // Randomized frames, expectations from the model alone.
      for (int r = 0; r < 30; r++) begin
         int n;
         if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(257, 400));
         else n = int'($urandom_range(1, 8));
         build(n, $urandom_range(0, 3) == 0);
         model();
         run_frame(int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1, m_done, m_err, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses. It holds the CPU in clear until a complete frame with a correct checksum has been loaded.

## Interface
- ADDR_W, 8, instruction-memory word-address width (matches the CPU's PC[7:0] ROM addressing)
- WORDS, 256, maximum accepted word count; must be ≤ 2^ADDR_W

- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  reset; one clock, and reset is asynchronous and active-high
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, RUN or ERR
- rx_data  in  8  incoming frame byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte; a byte transfers on an edge where rx_valid && rx_ready
- mem_addr  out  ADDR_W  instruction-memory write address (word index)
- mem_data  out  32  instruction word to write
- mem_we  out  1  write strobe, one cycle per word
- cpu_clr  out  1  clear to the CPU; high except in RUN
- done  out  1  program loaded and verified; high in RUN
- error  out  1  load failed; high in ERR

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 data bytes (each word MSB first), then one checksum byte equal to the XOR of all 4N data bytes. Length bytes are not included in the checksum.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR.
- IDLE: reached from reset. rx_ready=0. start → LEN_HI.
- LEN_HI, LEN_LO, DATA, CSUM: rx_ready=1, decoded from the state register.
- LEN_HI: on byte accept, capture N[15:8] → LEN_LO.
- LEN_LO: on byte accept, capture N[7:0]. If N==0 or N>WORDS → ERR. Otherwise clear the word index, byte index and XOR accumulator → DATA.
- DATA: each accepted byte shifts into a 32-bit assembly register and is XORed into the accumulator. The byte index counts 0..3. On the 4th byte, the assembled word is copied to mem_data, mem_addr is set to the word index, and mem_we is set for the next cycle. The word index then increments. After word N-1 → CSUM.
- CSUM: on byte accept, compare the byte with the accumulator. Match → RUN. Mismatch → ERR.
- RUN: cpu_clr=0, done=1. start → LEN_HI.
- ERR: error=1, cpu_clr=1. start → LEN_HI.
- start is ignored in LEN_HI, LEN_LO, DATA and CSUM.
- The mem_data/mem_addr registers are separate from the assembly register, so a byte accepted while mem_we=1 does not corrupt the pending write.
- Memory contents are never cleared by the loader. After an error or reset, partially written words remain in memory.

## Timing
- Reset values: rx_ready=0, mem_addr=0, mem_data=0, mem_we=0, cpu_clr=1, done=0, error=0, state=IDLE.
- Assertion of clr mid-operation forces the reset values immediately. A new start is required afterwards.
- The loader accepts at most one byte per cycle. Back-to-back bytes are accepted with no bubbles. Gaps in rx_valid only stall the loader.
- start accepted at edge t: rx_ready=1 from cycle t+1. In RUN, cpu_clr=1 and done=0 from cycle t+1.
- Word write: mem_we is high for exactly the cycle after the 4th byte is accepted, with mem_addr and mem_data stable during that cycle. mem_addr and mem_data hold their value afterwards.
- Checksum byte accepted at edge t: done=1 and cpu_clr=0 (or error=1) from cycle t+1. The final mem_we cycle always occurs at or before cycle t, so the CPU never leaves clear before the last write completes.
- Length error: error=1 the cycle after LEN_LO is accepted. No mem_we is issued for that frame.
- Word index width is ADDR_W+1 so that N=WORDS=256 terminates without wrap. mem_addr carries the low ADDR_W bits of the word index.

## Test plan
- Good load: start; bytes 00 02 | 00 00 00 01 | 12 34 56 78 | 09. Expect mem_we writes addr0=0x00000001 and addr1=0x12345678, then done=1 and cpu_clr=0 the cycle after byte 09, error=0.
- Bad checksum: same frame with final byte 00. Expect both writes still occur, then error=1, cpu_clr stays 1, done=0. A following start plus the correct frame ends with done=1.
- Length bounds: N=0x0000 gives error=1 the cycle after LEN_LO with no mem_we. N=0x0101 gives the same. N=0x0100 with 1024 bytes writes addresses 0..255 and ends in done.
- Flow control: good-load frame with rx_valid high only on alternate cycles, plus start pulsed mid-DATA. Expect identical writes, exactly one mem_we per word, and start ignored.
- Reset mid-load: assert clr after the 6th byte of the good frame. Expect all outputs at reset values the same cycle and rx_ready=0. A subsequent start plus the full frame yields done=1.
- Reload from RUN: after a good load, pulse start. Expect cpu_clr=1 and done=0 on the next cycle, rx_ready=1, and normal loading of a second frame.
